beta_mem_arbiter: RTL and testbench

Shares one single-ported memory bus between the Beta core's instruction-fetch port and data port. Sequences each access as grant -> bus cycle -> response, round-robin on contention. Drives the core's instructionReady/dataReady and iMemfault/dMemfault handshakes, which are currently tied high/low at the top level. Sits between Beta_core and the memory (or the MMU once it is populated).

---
 rtl/beta_mem_pkg.sv | 37 +++
 rtl/beta_mem_arbiter_timer.sv | 42 ++++
 rtl/beta_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_beta_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_mem_pkg.sv
// beta_mem_pkg
//   Shared types and defaults for the Beta memory-bus arbiter.
//   - arb_state_t : arbiter sequencing states (IDLE -> BUSY -> RESP)
//   - arb_grant_t : which core port owns the bus (fetch or data)
//   - BETA_ADDR_W / BETA_DATA_W / BETA_TIMEOUT : default widths and bus-cycle limit
//   - pick_grant  : round-robin selection between the two requesters
package beta_mem_pkg;

  localparam int unsigned BETA_ADDR_W  = 32;
  localparam int unsigned BETA_DATA_W  = 32;
  localparam int unsigned BETA_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_grant_t;

  // On contention the side that did not win last time is served.
  function automatic arb_grant_t pick_grant(input logic       fetch_req,
                                            input logic       data_req,
                                            input arb_grant_t last);
    if (fetch_req && data_req) begin
      return (last == GNT_D) ? GNT_I : GNT_D;
    end else if (data_req) begin
      return GNT_D;
    end else begin
      return GNT_I;
    end
  endfunction

endpackage

// File: rtl/beta_mem_arbiter_timer.sv
// beta_arb_timer
//   Bus-cycle watchdog for the arbiter. Counts cycles while enabled and
//   flags expiry on the TIMEOUT-th enabled cycle since the last clear.
//   Only instantiated when BETA_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   i_clear   in   zero the counter (held while the bus is not busy)
//   i_enable  in   count this cycle (bus busy)
//   o_expired out  this enabled cycle is the TIMEOUT-th one (TIMEOUT >= 1)
module beta_arb_timer
  import beta_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = BETA_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_limit;

  // Count value k during the (k+1)-th busy cycle, so the limit is hit on
  // busy cycle number TIMEOUT; the counter saturates there.
  assign w_at_limit = (r_count == LAST);
  assign o_expired  = i_enable && w_at_limit;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/beta_mem_arbiter.sv
// beta_mem_arbiter
//   Shares one single-ported memory bus between the Beta core's fetch port
//   and data port. Each access runs grant -> bus cycle -> response; the two
//   sides are served round-robin on contention (fetch first after reset).
//   Optional macro BETA_ARB_TIMEOUT_EN: abort a bus cycle that has not seen
//   m_ready within TIMEOUT cycles, returning fault=1 and rdata=0.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_req, i_addr                fetch request (held until i_ready)
//   i_rdata, i_ready, i_fault    fetch response (one-cycle ready pulse)
//   d_re, d_we, d_addr, d_wdata  data request (held until d_ready; we wins)
//   d_rdata, d_ready, d_fault    data response (one-cycle ready pulse)
//   m_addr, m_wdata, m_re, m_we  memory bus command (registered, stable in BUSY)
//   m_rdata, m_ready, m_fault    memory completion
module beta_mem_arbiter
  import beta_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = BETA_ADDR_W,
  parameter int unsigned DATA_W  = BETA_DATA_W,
  parameter int unsigned TIMEOUT = BETA_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              i_fault,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_fault,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_re,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  input  logic              m_fault
);

  arb_state_t        r_state;
  arb_grant_t        r_grant;   // current owner while busy, last winner otherwise
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              r_m_re;
  logic              r_m_we;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;
  logic              r_i_fault;
  logic              r_d_fault;

  logic              w_d_req;
  logic              w_any_req;
  arb_grant_t        w_pick;

  assign w_d_req   = d_re | d_we;
  assign w_any_req = i_req | w_d_req;
  assign w_pick    = pick_grant(i_req, w_d_req, r_grant);

`ifdef BETA_ARB_TIMEOUT_EN
  logic w_tmr_en;
  logic w_tmr_clear;
  logic w_expired;

  // Held clear outside BUSY, so every bus cycle starts counting from zero.
  assign w_tmr_en    = (r_state == ST_BUSY);
  assign w_tmr_clear = ~w_tmr_en;

  beta_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmr_clear),
    .i_enable (w_tmr_en),
    .o_expired(w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= GNT_D;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_re    <= 1'b0;
      r_m_we    <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_fault <= 1'b0;
      r_d_fault <= 1'b0;
    end else begin
      // Ready/fault are single-cycle: raised on the BUSY->RESP edge and
      // dropped on the RESP->IDLE edge by these defaults.
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_fault <= 1'b0;
      r_d_fault <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_BUSY;
            r_grant <= w_pick;
            if (w_pick == GNT_D) begin
              r_m_addr  <= d_addr;
              r_m_wdata <= d_wdata;
              r_m_we    <= d_we;
              r_m_re    <= ~d_we;
            end else begin
              r_m_addr  <= i_addr;
              r_m_wdata <= '0;
              r_m_we    <= 1'b0;
              r_m_re    <= 1'b1;
            end
          end
        end

        ST_BUSY: begin
          if (m_ready) begin
            r_state <= ST_RESP;
            r_m_re  <= 1'b0;
            r_m_we  <= 1'b0;
            if (r_grant == GNT_D) begin
              r_d_ready <= 1'b1;
              r_d_fault <= m_fault;
              if (!r_m_we) begin
                r_d_rdata <= m_rdata;
              end
            end else begin
              r_i_ready <= 1'b1;
              r_i_fault <= m_fault;
              r_i_rdata <= m_rdata;
            end
          end
`ifdef BETA_ARB_TIMEOUT_EN
          else if (w_expired) begin
            r_state <= ST_RESP;
            r_m_re  <= 1'b0;
            r_m_we  <= 1'b0;
            if (r_grant == GNT_D) begin
              r_d_ready <= 1'b1;
              r_d_fault <= 1'b1;
              r_d_rdata <= '0;
            end else begin
              r_i_ready <= 1'b1;
              r_i_fault <= 1'b1;
              r_i_rdata <= '0;
            end
          end
`endif
        end

        // No grant here: a requester still high during its ready cycle
        // must not be served twice.
        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_re    = r_m_re;
  assign m_we    = r_m_we;
  assign i_rdata = r_i_rdata;
  assign i_ready = r_i_ready;
  assign i_fault = r_i_fault;
  assign d_rdata = r_d_rdata;
  assign d_ready = r_d_ready;
  assign d_fault = r_d_fault;

endmodule

// File: tb/tb_beta_mem_arbiter.sv
module tb_beta_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef BETA_ARB_TIMEOUT_EN
  localparam int unsigned WR_WAIT = 4;
`else
  localparam int unsigned WR_WAIT = 5;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready, i_fault;
  logic          d_re, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_ready, d_fault;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_re, m_we, m_ready, m_fault;

  beta_mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_fault(i_fault),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_fault(d_fault),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_re(m_re), .m_we(m_we),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_fault(m_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          side_d;
    logic [DW-1:0] rdata;
    logic          fault;
  } rsp_t;

  rsp_t          exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] d_mdl = '0;   // what d_rdata should hold (writes leave it alone)

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  task automatic push_exp(input logic side_d, input logic [DW-1:0] rdata, input logic fault);
    rsp_t e;
    e.side_d = side_d;
    e.rdata  = rdata;
    e.fault  = fault;
    exp_q.push_back(e);
  endtask

  // Monitor: every response pulse is matched against the scoreboard queue.
  initial begin
    rsp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (i_ready || d_ready) begin
        if (i_ready && d_ready) begin
          fail("ready_overlap");
        end else if (exp_q.size() == 0) begin
          fail("unexpected_ready");
        end else begin
          e = exp_q.pop_front();
          check("ready_side", d_ready, e.side_d);
          if (d_ready) begin
            check("d_rdata", d_rdata, e.rdata);
            check("d_fault", d_fault, e.fault);
            check("i_fault_quiet", i_fault, 1'b0);
          end else begin
            check("i_rdata", i_rdata, e.rdata);
            check("i_fault", i_fault, e.fault);
            check("d_fault_quiet", d_fault, 1'b0);
          end
        end
      end else begin
        check("fault_quiet", {i_fault, d_fault}, 2'b00);
      end
    end
  end

  // Randomised traffic with a behavioural memory and round-robin reference.
  task automatic run_random(input int unsigned ncyc);
    logic          outstanding = 1'b0, cur_d = 1'b0, last_d = 1'b1, is_wr = 1'b0;
    logic          i_done = 1'b0, d_done = 1'b0, exp_d;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    int unsigned   wait_cnt = 0, i_gap = 0, d_gap = 0, stall = 0, cyc = 0, t;
    s_addr  = '0;
    s_wdata = '0;
    while (cyc < ncyc || i_req || d_re || d_we || outstanding || m_ready) begin
      @(negedge clk);
      cyc++;
      if (cyc > ncyc + 200) begin
        fail("random_drain_timeout");
        break;
      end
      if (m_ready) begin
        check("strobe_drop", {m_re, m_we}, 2'b00);
        m_ready = 1'b0;
        m_fault = 1'b0;
        outstanding = 1'b0;
        if (cur_d) d_done = 1'b1; else i_done = 1'b1;
      end else if (outstanding) begin
        check("hold_addr", m_addr, s_addr);
        check("hold_strobe", {m_re, m_we}, {~is_wr, is_wr});
        if (is_wr) check("hold_wdata", m_wdata, s_wdata);
      end else if (m_re || m_we) begin
        if (!i_req && !(d_re || d_we)) fail("grant_without_request");
        exp_d   = (i_req && (d_re || d_we)) ? ~last_d : (d_re | d_we);
        is_wr   = exp_d && d_we;
        s_addr  = exp_d ? d_addr : i_addr;
        s_wdata = d_wdata;
        check("grant_addr", m_addr, s_addr);
        check("grant_strobe", {m_re, m_we}, {~is_wr, is_wr});
        if (is_wr) check("grant_wdata", m_wdata, s_wdata);
        last_d      = exp_d;
        cur_d       = exp_d;
        outstanding = 1'b1;
        wait_cnt    = $urandom_range(0, 3);
      end

      if (outstanding && !m_ready) begin
        if (wait_cnt == 0) begin
          m_ready = 1'b1;
          m_rdata = $urandom;
          m_fault = ($urandom_range(0, 3) == 0);
          if (cur_d && !is_wr) d_mdl = m_rdata;
          push_exp(cur_d, cur_d ? d_mdl : m_rdata, m_fault);
        end else begin
          wait_cnt--;
        end
      end

      if (i_done) begin
        i_req  = 1'b0;
        i_done = 1'b0;
        i_gap  = $urandom_range(0, 2);
      end
      if (!i_req && cyc < ncyc) begin
        if (i_gap == 0) begin
          i_req  = 1'b1;
          i_addr = $urandom;
        end else begin
          i_gap--;
        end
      end
      if (d_done) begin
        d_re   = 1'b0;
        d_we   = 1'b0;
        d_done = 1'b0;
        d_gap  = $urandom_range(0, 2);
      end
      if (!(d_re || d_we) && cyc < ncyc) begin
        if (d_gap == 0) begin
          t       = $urandom_range(0, 2);
          d_re    = (t != 1);
          d_we    = (t != 0);
          d_addr  = $urandom;
          d_wdata = $urandom;
        end else begin
          d_gap--;
        end
      end

      if (!outstanding && (i_req || d_re || d_we)) stall++; else stall = 0;
      if (stall > 10) begin
        fail("request_starved");
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_re = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ready = 1'b0; m_fault = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_re", m_re, 1'b0);
    check("rst_m_we", m_we, 1'b0);
    check("rst_m_addr", m_addr, '0);
    check("rst_m_wdata", m_wdata, '0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    check("rst_ready", {i_ready, d_ready}, 2'b00);
    check("rst_fault", {i_fault, d_fault}, 2'b00);
    rst = 1'b0;

    // Single fetch: strobe in cycle 1, ready in cycle 2, idle in cycle 3.
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    check("fetch_strobe", {m_re, m_we}, 2'b10);
    check("fetch_m_addr", m_addr, 32'h100);
    m_ready = 1'b1; m_rdata = 32'hDEADBEEF;
    push_exp(1'b0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("fetch_i_ready", i_ready, 1'b1);
    check("fetch_strobe_drop", m_re, 1'b0);
    m_ready = 1'b0; i_req = 1'b0;
    @(negedge clk);
    check("fetch_pulse_end", i_ready, 1'b0);
    check("fetch_idle", {m_re, m_we}, 2'b00);

    // Data read returning a fault.
    d_re = 1'b1; d_addr = 32'h200;
    @(negedge clk);
    check("dfault_strobe", {m_re, m_we}, 2'b10);
    check("dfault_m_addr", m_addr, 32'h200);
    m_ready = 1'b1; m_fault = 1'b1; m_rdata = 32'hCAFE0001;
    d_mdl = 32'hCAFE0001;
    push_exp(1'b1, 32'hCAFE0001, 1'b1);
    @(negedge clk);
    check("dfault_d_ready", {d_ready, d_fault}, 2'b11);
    check("dfault_i_side", {i_ready, i_fault}, 2'b00);
    m_ready = 1'b0; m_fault = 1'b0; d_re = 1'b0;
    @(negedge clk);

    // Slow write: command held stable, d_rdata untouched.
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    for (int unsigned k = 0; k < WR_WAIT; k++) begin
      @(negedge clk);
      check("wr_strobe", {m_re, m_we}, 2'b01);
      check("wr_m_addr", m_addr, 32'h40);
      check("wr_m_wdata", m_wdata, 32'h12345678);
      check("wr_no_ready", d_ready, 1'b0);
    end
    m_ready = 1'b1; m_rdata = 32'h0BADF00D;
    push_exp(1'b1, d_mdl, 1'b0);
    @(negedge clk);
    check("wr_d_ready", d_ready, 1'b1);
    check("wr_d_rdata_kept", d_rdata, 32'hCAFE0001);
    m_ready = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("wr_single_pulse", d_ready, 1'b0);

    // Reset in the middle of a bus cycle.
    i_req = 1'b1; i_addr = 32'h300;
    @(negedge clk);
    check("rstmid_busy", m_re, 1'b1);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    check("rstmid_strobe_drop", {m_re, m_we}, 2'b00);
    check("rstmid_no_ready", {i_ready, d_ready}, 2'b00);
    check("rstmid_d_rdata", d_rdata, '0);
    rst = 1'b0; d_mdl = '0;
    @(negedge clk);
    check("rstmid_still_quiet", {i_ready, d_ready}, 2'b00);

    // Contention right after reset: fetch first, then data.
    i_req = 1'b1; i_addr = 32'h500; d_re = 1'b1; d_addr = 32'h600;
    @(negedge clk);
    check("cont_first_fetch", m_addr, 32'h500);
    m_ready = 1'b1; m_rdata = 32'h11110000;
    push_exp(1'b0, 32'h11110000, 1'b0);
    @(negedge clk);
    m_ready = 1'b0; i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cont_then_data", m_addr, 32'h600);
    check("cont_data_strobe", {m_re, m_we}, 2'b10);
    m_ready = 1'b1; m_rdata = 32'h22220000;
    d_mdl = 32'h22220000;
    push_exp(1'b1, 32'h22220000, 1'b0);
    @(negedge clk);
    m_ready = 1'b0; d_re = 1'b0;
    @(negedge clk);

    run_random(800);
    repeat (2) @(negedge clk);

`ifdef BETA_ARB_TIMEOUT_EN
    // Memory never answers: forced fault after 4 busy cycles.
    i_req = 1'b1; i_addr = 32'h700;
    push_exp(1'b0, '0, 1'b1);
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      check("tmo_busy", m_re, 1'b1);
      check("tmo_no_ready", i_ready, 1'b0);
    end
    @(negedge clk);
    check("tmo_ready", {i_ready, i_fault}, 2'b11);
    check("tmo_rdata", i_rdata, '0);
    check("tmo_strobe_drop", m_re, 1'b0);
    i_req = 1'b0;
    @(negedge clk);
    m_ready = 1'b1; m_fault = 1'b1; m_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    m_ready = 1'b0; m_fault = 1'b0;
    check("late_ready_ignored", {i_ready, d_ready, m_re, m_we}, 4'b0000);
    @(negedge clk);
    check("late_ready_idle", {i_ready, d_ready, m_re, m_we}, 4'b0000);
`else
    // Without the watchdog a silent memory keeps the arbiter busy.
    i_req = 1'b1; i_addr = 32'h700;
    repeat (100) @(negedge clk);
    check("no_tmo_busy", m_re, 1'b1);
    check("no_tmo_addr", m_addr, 32'h700);
    check("no_tmo_no_ready", i_ready, 1'b0);
    m_ready = 1'b1; m_rdata = 32'h77777777;
    push_exp(1'b0, 32'h77777777, 1'b0);
    @(negedge clk);
    m_ready = 1'b0; i_req = 1'b0;
    check("no_tmo_ready", i_ready, 1'b1);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
